// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing RAM port A among NUM_REQ requesters.
// Registers the winning command onto the RAM port and routes read data back with a strobe.
module ram_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_REQ    = 3
) (
    input  logic                          i_clk,
    input  logic                          i_resetn,
    input  logic                          i_enable,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
    output logic [NUM_REQ-1:0]            o_ack,
    output logic [NUM_REQ-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic [ADDR_WIDTH-1:0]         o_ram_addr,
    output logic [DATA_WIDTH-1:0]         o_ram_din,
    output logic                          o_ram_we,
    output logic                          o_ram_re,
    input  logic [DATA_WIDTH-1:0]         i_ram_dout
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      r_ptr;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_din;
    logic                  r_ram_we;
    logic                  r_ram_re;
    logic                  r_s1_valid;
    logic [PTR_W-1:0]      r_s1_idx;
    logic [NUM_REQ-1:0]    r_rvalid;

    logic                  w_grant;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [NUM_REQ-1:0]    w_ack;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_we;

    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base, input int ofs);
        int s;
        s = (int'(base) + ofs) % int'(NUM_REQ);
        return PTR_W'(s);
    endfunction

    // Scan from farthest to nearest so the nearest set bit after r_ptr wins.
    always_comb begin
        w_gnt_idx = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            if (i_req[rr_idx(r_ptr, k)]) begin
                w_gnt_idx = rr_idx(r_ptr, k);
            end
        end
    end

    assign w_grant = i_resetn && i_enable && (|i_req);
    assign w_ack   = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;

    always_comb begin
        w_addr  = '0;
        w_wdata = '0;
        w_we    = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_ack[i]) begin
                w_addr  = i_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_wdata = i_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_we    = i_we[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_ptr      <= PTR_W'(NUM_REQ - 1);
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_ram_we   <= 1'b0;
            r_ram_re   <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
            r_rvalid   <= '0;
        end else begin
            r_ram_we   <= w_grant && w_we;
            r_ram_re   <= w_grant && !w_we;
            if (w_grant) begin
                r_ptr      <= w_gnt_idx;
                r_ram_addr <= w_addr;
                r_ram_din  <= w_wdata;
            end
            // Stage 1 travels with the command; stage 2 lines up with RAM read data.
            r_s1_valid <= w_grant && !w_we;
            r_s1_idx   <= w_gnt_idx;
            r_rvalid   <= r_s1_valid ? (NUM_REQ'(1) << r_s1_idx) : '0;
        end
    end

    assign o_ack      = w_ack;
    assign o_rvalid   = r_rvalid;
    assign o_rdata    = i_ram_dout;
    assign o_ram_addr = r_ram_addr;
    assign o_ram_din  = r_ram_din;
    assign o_ram_we   = r_ram_we;
    assign o_ram_re   = r_ram_re;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a one-cycle-latency RAM model on port A.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [5:0]  addr_a [3];
    logic [7:0]  wdata_a [3];
    logic [17:0] addr_flat;
    logic [23:0] wdata_flat;
    logic [2:0]  ack;
    logic [2:0]  rvalid;
    logic [7:0]  rdata;
    logic [5:0]  ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        ram_re;
    logic [7:0]  ram_dout;
    logic [7:0]  mem [64];

    int n_checks = 0;
    int n_fail   = 0;

    assign addr_flat  = {addr_a[2], addr_a[1], addr_a[0]};
    assign wdata_flat = {wdata_a[2], wdata_a[1], wdata_a[0]};

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(6),
        .NUM_REQ   (3)
    ) dut (
        .i_clk     (clk),
        .i_resetn  (resetn),
        .i_enable  (enable),
        .i_req     (req),
        .i_we      (we),
        .i_addr    (addr_flat),
        .i_wdata   (wdata_flat),
        .o_ack     (ack),
        .o_rvalid  (rvalid),
        .o_rdata   (rdata),
        .o_ram_addr(ram_addr),
        .o_ram_din (ram_din),
        .o_ram_we  (ram_we),
        .o_ram_re  (ram_re),
        .i_ram_dout(ram_dout)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        req    = 3'b111;
        we     = 3'b000;
        @(negedge clk);
        check_eq("ack_in_reset", 32'(ack), 32'h0);
        tick();
        tick();
        resetn = 1'b1;
        req    = 3'b000;
    endtask

    // Expected read data: memory preloaded with 0x80+addr, except mem[5]=0xA3.
    function automatic logic [7:0] exp_mem(input int a);
        return (a == 5) ? 8'hA3 : 8'(8'h80 + a);
    endfunction

    logic [2:0] rr_ack [4];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(8'h80 + i);
        mem[5] = 8'hA3;
        for (int i = 0; i < 3; i++) begin
            addr_a[i]  = '0;
            wdata_a[i] = '0;
        end
        resetn = 1'b0;
        enable = 1'b1;
        req    = '0;
        we     = '0;
        rr_ack[0] = 3'b001;
        rr_ack[1] = 3'b010;
        rr_ack[2] = 3'b100;
        rr_ack[3] = 3'b001;

        do_reset();
        @(negedge clk);
        check_eq("rst_ram_we", 32'(ram_we), 32'h0);
        check_eq("rst_ram_re", 32'(ram_re), 32'h0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
        check_eq("rst_ram_din", 32'(ram_din), 32'h0);
        check_eq("rst_rvalid", 32'(rvalid), 32'h0);
        tick();

        // Single read of addr 5 by requester 0.
        req = 3'b001; we = 3'b000; addr_a[0] = 6'd5;
        @(negedge clk); check_eq("rd_ack", 32'(ack), 32'h1);
        tick(); req = 3'b000;
        @(negedge clk);
        check_eq("rd_ram_re", 32'(ram_re), 32'h1);
        check_eq("rd_ram_we", 32'(ram_we), 32'h0);
        check_eq("rd_ram_addr", 32'(ram_addr), 32'd5);
        tick();
        @(negedge clk);
        check_eq("rd_rvalid", 32'(rvalid), 32'h1);
        check_eq("rd_rdata", 32'(rdata), 32'hA3);
        tick();

        // Requester 1 writes 0x5C to addr 12, then reads it back.
        req = 3'b010; we = 3'b010; addr_a[1] = 6'd12; wdata_a[1] = 8'h5C;
        @(negedge clk); check_eq("wr_ack", 32'(ack), 32'h2);
        tick(); we = 3'b000;
        @(negedge clk);
        check_eq("wr_ram_we", 32'(ram_we), 32'h1);
        check_eq("wr_ram_addr", 32'(ram_addr), 32'd12);
        check_eq("wr_ram_din", 32'(ram_din), 32'h5C);
        check_eq("wr_rd_ack", 32'(ack), 32'h2);
        check_eq("wr_no_rvalid", 32'(rvalid), 32'h0);
        tick(); req = 3'b000;
        @(negedge clk);
        check_eq("wr_rd_ram_re", 32'(ram_re), 32'h1);
        check_eq("wr_rd_ram_we", 32'(ram_we), 32'h0);
        check_eq("wr_no_rvalid2", 32'(rvalid), 32'h0);
        tick();
        @(negedge clk);
        check_eq("wr_rd_rvalid", 32'(rvalid), 32'h2);
        check_eq("wr_rd_rdata", 32'(rdata), 32'h5C);
        tick();

        // Round-robin from reset with all three reading.
        do_reset();
        addr_a[0] = 6'd1; addr_a[1] = 6'd2; addr_a[2] = 6'd3;
        for (int c = 0; c < 6; c++) begin
            req = (c < 4) ? 3'b111 : 3'b000;
            we  = 3'b000;
            @(negedge clk);
            check_eq($sformatf("rr_ack%0d", c), 32'(ack), (c < 4) ? 32'(rr_ack[c]) : 32'h0);
            if (c >= 2) begin
                check_eq($sformatf("rr_rvalid%0d", c), 32'(rvalid), 32'(rr_ack[c-2]));
                check_eq($sformatf("rr_rdata%0d", c), 32'(rdata),
                         32'(exp_mem((c == 5) ? 1 : c - 1)));
            end
            tick();
        end

        // Streaming reads of addrs 0..7 by requester 2.
        for (int c = 0; c < 11; c++) begin
            req = (c < 8) ? 3'b100 : 3'b000;
            we  = 3'b000;
            addr_a[2] = 6'(c);
            @(negedge clk);
            check_eq($sformatf("st_ack%0d", c), 32'(ack), (c < 8) ? 32'h4 : 32'h0);
            if (c >= 2 && c < 10) begin
                check_eq($sformatf("st_rvalid%0d", c), 32'(rvalid), 32'h4);
                check_eq($sformatf("st_rdata%0d", c), 32'(rdata), 32'(exp_mem(c - 2)));
            end else begin
                check_eq($sformatf("st_rvalid%0d", c), 32'(rvalid), 32'h0);
            end
            tick();
        end

        // Enable stall with req=011; pointer rests on requester 2.
        enable = 1'b0; req = 3'b011; we = 3'b000;
        addr_a[0] = 6'h20; addr_a[1] = 6'h21;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("en_ack%0d", c), 32'(ack), 32'h0);
            check_eq($sformatf("en_ram_re%0d", c), 32'(ram_re), 32'h0);
            check_eq($sformatf("en_ram_we%0d", c), 32'(ram_we), 32'h0);
            tick();
        end
        enable = 1'b1;
        @(negedge clk); check_eq("en_first_ack", 32'(ack), 32'h1);
        tick();
        @(negedge clk);
        check_eq("en_second_ack", 32'(ack), 32'h2);
        check_eq("en_ram_addr", 32'(ram_addr), 32'h20);
        tick(); req = 3'b000;
        tick(); tick(); tick();

        // Reset while a read is in flight; pointer sits at 0 before reset.
        req = 3'b001; addr_a[0] = 6'd5;
        @(negedge clk); check_eq("mr_ack", 32'(ack), 32'h1);
        tick(); req = 3'b000; resetn = 1'b0;
        @(negedge clk); check_eq("mr_ram_re", 32'(ram_re), 32'h1);
        tick(); resetn = 1'b1;
        @(negedge clk); check_eq("mr_rvalid_t2", 32'(rvalid), 32'h0);
        tick(); req = 3'b011;
        @(negedge clk);
        check_eq("mr_rvalid_t3", 32'(rvalid), 32'h0);
        check_eq("mr_first_ack", 32'(ack), 32'h1);
        tick(); req = 3'b000;
        @(negedge clk); check_eq("mr_rvalid_t4", 32'(rvalid), 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares port A of a dual-port synchronous RAM (one-cycle read latency, write-priority port) among `NUM_REQ` requesters, e.g. CPU, DMA and PPU palette/OAM accesses. It accepts at most one access per cycle, registers the winning command onto the RAM port, and routes the read data back to the originating requester with a valid strobe. Port B of the RAM is not touched by this block and stays free for a dedicated reader such as video scan-out.

## Interface
Parameters:
- `DATA_WIDTH`, 8, RAM word width
- `ADDR_WIDTH`, 6, RAM address width
- `NUM_REQ`, 3, number of requesters (2..8)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `resetn`  in  1  synchronous, active-low reset
- `enable`  in  1  1 = grants allowed; 0 = no new grants, in-flight reads still complete
- `req`  in  NUM_REQ  per-requester access request, level
- `we`  in  NUM_REQ  per-requester: 1 = write, 0 = read
- `addr`  in  NUM_REQ*ADDR_WIDTH  flattened; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `wdata`  in  NUM_REQ*DATA_WIDTH  flattened, same slicing as `addr`
- `ack`  out  NUM_REQ  one-hot combinational grant pulse, at most one bit set
- `rvalid`  out  NUM_REQ  one-hot registered read-data strobe
- `rdata`  out  DATA_WIDTH  shared read data = `ram_dout`, valid only while some `rvalid` bit is set
- `ram_addr`  out  ADDR_WIDTH  registered RAM port-A address
- `ram_din`  out  DATA_WIDTH  registered RAM port-A write data
- `ram_we`  out  1  registered RAM port-A write enable
- `ram_re`  out  1  registered RAM port-A read enable
- `ram_dout`  in  DATA_WIDTH  RAM port-A read data

## Operation
- Handshake: a requester holds `req`, `we`, `addr` and `wdata` stable until it sees `ack[i]` high at a clock edge. It may then drop `req` or present a new access in the next cycle. There is no cap on outstanding reads per requester.
- Arbitration is combinational in cycle T. If `enable`=1, `resetn`=1 and any `req` bit is set, exactly one `ack[g]` is raised.
- Winner `g` is the first set `req` bit scanning upward from `ptr+1`, mod NUM_REQ.
- `ptr` (width clog2(NUM_REQ)) loads `g` on every grant and is unchanged otherwise. Its reset value is NUM_REQ-1, so requester 0 has first priority.
- At the edge ending T the block registers:
  - `ram_addr` <= `addr[g]`, `ram_din` <= `wdata[g]`
  - `ram_we` <= `we[g]`, `ram_re` <= !`we[g]`
- Cycle with no grant: `ram_we`=`ram_re`=0. `ram_addr` and `ram_din` hold their previous values.
- Read return pipeline: a stage-1 register {valid, g} is captured with the command. It advances to stage 2 one cycle later. `rvalid[g]` = stage-2 valid.
- Writes never produce `rvalid`.
- `ptr` advances on reads and writes alike, so a requester never waits more than NUM_REQ-1 grants while its `req` stays high.

## Timing
- Read: `ack` in cycle T; `ram_re`=1 in T+1; `rvalid[g]`=1 and `rdata`=mem[addr] in T+2. Read latency is 2 cycles from ack.
- Write: `ack` in T; `ram_we`=1 in T+1; the RAM is updated at the end of T+1. A read of the same address granted in T+1 or later returns the new data.
- Throughput: one access per cycle. Back-to-back reads produce `rvalid` on consecutive cycles.
- `enable` falling in cycle T: `ack`=0 from T onward. Reads granted before T still return on schedule.
- Reset (`resetn`=0 sampled at an edge):
  - `ram_we`, `ram_re`, `ram_addr`, `ram_din` and both pipeline stages clear to 0; `ptr` = NUM_REQ-1.
  - `ack` is forced to 0 while `resetn`=0.
  - Reads in flight at reset are dropped: no `rvalid` in the cycles after release.
- Reset values: `ack`=0, `rvalid`=0, `ram_*`=0. `rdata` mirrors `ram_dout` and has no reset.
- `req` rising in the same cycle as another requester's grant is arbitrated from the next cycle. There is no request queueing inside the block.

## Test plan
- Single read: memory model holds mem[5]=0xA3; req0 read addr 5 -> `ack`=001 in T, `ram_re`=1 with `ram_addr`=5 in T+1, `rvalid`=001 and `rdata`=0xA3 in T+2.
- Write then read: req1 writes 0x5C to addr 12, then immediately reads addr 12 -> `ram_we` pulse at T+1; read returns 0x5C with `rvalid`=010 three cycles after the write ack.
- Round-robin after reset: req=111 held, all reads -> ack order 001, 010, 100, 001 on four consecutive cycles; each `rvalid` follows its ack by 2 cycles.
- Streaming: req2 holds reads of addrs 0..7 for 8 cycles -> 8 consecutive `ack`, then 8 consecutive `rvalid`=100 with data in address order.
- Enable stall: req=011 with `enable`=0 for 3 cycles -> `ack`=0, `ram_we`=`ram_re`=0, `ptr` unchanged; on re-enable the first grant goes to the requester `ptr` selects.
- Reset mid-read: read acked in T, `resetn`=0 sampled at the end of T+1 -> `rvalid` stays 0 through T+4, and the first grant after release goes to requester 0.
